dac_spi_tx: RTL and testbench



---
 rtl/dac_spi_tx.sv | 174 +++++++++++++++++
 tb/tb_dac_spi_tx.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_tx.sv
// SPI transmitter for DAC121S101-class converters: one 16-bit frame per sample tick, MSB first.
// Define DAC_SPI_DUAL_EN to add a lockstep second data line (dac_din_b) for channel B.
module dac_spi_tx #(
  parameter int HALF_DIV   = 2,
  parameter int SAMPLE_DIV = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [11:0] sample_in,
  input  logic [11:0] sample_in_b,
  input  logic [1:0]  pd_mode,
  output logic        dac_sclk,
  output logic        dac_sync_n,
  output logic        dac_din,
  output logic        dac_din_b,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  overrun_cnt
);

  localparam int HW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_DIV - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);

  typedef enum logic [0:0] {IDLE, SHIFT} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [HW-1:0]   half_cnt_q, half_cnt_d;
  logic [3:0]      bit_idx_q, bit_idx_d;
  logic [15:0]     shreg_a_q, shreg_a_d;
  logic            sclk_q, sclk_d;
  logic            sync_n_q, sync_n_d;
  logic            din_q, din_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [7:0]      ovr_q, ovr_d;
  logic            tick;
  logic [15:0]     frame_a;

`ifdef DAC_SPI_DUAL_EN
  logic [15:0]     shreg_b_q, shreg_b_d;
  logic            din_b_q, din_b_d;
  logic [15:0]     frame_b;
  assign frame_b = {2'b00, pd_mode, sample_in_b};
`else
  logic            unused_b;
  assign unused_b = ^sample_in_b;
`endif

  assign tick    = enable && (tick_cnt_q == TICK_LAST);
  assign frame_a = {2'b00, pd_mode, sample_in};

  always_comb begin
    tick_cnt_d = '0;
    if (enable && !tick) tick_cnt_d = tick_cnt_q + TW'(1);

    state_d    = state_q;
    half_cnt_d = half_cnt_q;
    bit_idx_d  = bit_idx_q;
    shreg_a_d  = shreg_a_q;
    sclk_d     = sclk_q;
    sync_n_d   = sync_n_q;
    din_d      = din_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ovr_d      = ovr_q;
`ifdef DAC_SPI_DUAL_EN
    shreg_b_d  = shreg_b_q;
    din_b_d    = din_b_q;
`endif

    case (state_q)
      IDLE: begin
        if (tick) begin
          shreg_a_d  = frame_a;
          din_d      = frame_a[15];
`ifdef DAC_SPI_DUAL_EN
          shreg_b_d  = frame_b;
          din_b_d    = frame_b[15];
`endif
          sync_n_d   = 1'b0;
          busy_d     = 1'b1;
          bit_idx_d  = 4'd15;
          half_cnt_d = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        // A tick arriving while a frame is on the wire is dropped and counted.
        if (tick && ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
        if (half_cnt_q == HALF_LAST) begin
          half_cnt_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
          end else if (bit_idx_q == 4'd0) begin
            sclk_d   = 1'b1;
            sync_n_d = 1'b1;
            din_d    = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = IDLE;
`ifdef DAC_SPI_DUAL_EN
            din_b_d  = 1'b0;
`endif
          end else begin
            sclk_d    = 1'b1;
            bit_idx_d = bit_idx_q - 4'd1;
            shreg_a_d = {shreg_a_q[14:0], 1'b0};
            din_d     = shreg_a_q[14];
`ifdef DAC_SPI_DUAL_EN
            shreg_b_d = {shreg_b_q[14:0], 1'b0};
            din_b_d   = shreg_b_q[14];
`endif
          end
        end else begin
          half_cnt_d = half_cnt_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      half_cnt_q <= '0;
      bit_idx_q  <= '0;
      shreg_a_q  <= '0;
      sclk_q     <= 1'b1;
      sync_n_q   <= 1'b1;
      din_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= '0;
`ifdef DAC_SPI_DUAL_EN
      shreg_b_q  <= '0;
      din_b_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      half_cnt_q <= half_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_a_q  <= shreg_a_d;
      sclk_q     <= sclk_d;
      sync_n_q   <= sync_n_d;
      din_q      <= din_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
`ifdef DAC_SPI_DUAL_EN
      shreg_b_q  <= shreg_b_d;
      din_b_q    <= din_b_d;
`endif
    end
  end

  assign dac_sclk    = sclk_q;
  assign dac_sync_n  = sync_n_q;
  assign dac_din     = din_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign overrun_cnt = ovr_q;
`ifdef DAC_SPI_DUAL_EN
  assign dac_din_b   = din_b_q;
`else
  assign dac_din_b   = 1'b0;
`endif

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: two instances (SAMPLE_DIV 100 and 40) checked every cycle
// against a frame-schedule model, plus literal checks of launch times, frame bits and overruns.
module tb_dac_spi_tx;
  localparam int H = 2;
`ifdef DAC_SPI_DUAL_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, enable;
  logic [11:0] sample_in, sample_in_b;
  logic [1:0]  pd_mode;
  logic [1:0]  sclk, sync_n, din, din_b, busy, done;
  logic [1:0][7:0] ovr;

  dac_spi_tx dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_in(sample_in),
    .sample_in_b(sample_in_b), .pd_mode(pd_mode), .dac_sclk(sclk[0]),
    .dac_sync_n(sync_n[0]), .dac_din(din[0]), .dac_din_b(din_b[0]),
    .busy(busy[0]), .frame_done(done[0]), .overrun_cnt(ovr[0])
  );

  dac_spi_tx #(.HALF_DIV(2), .SAMPLE_DIV(40)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_in(sample_in),
    .sample_in_b(sample_in_b), .pd_mode(pd_mode), .dac_sclk(sclk[1]),
    .dac_sync_n(sync_n[1]), .dac_din(din[1]), .dac_din_b(din_b[1]),
    .busy(busy[1]), .frame_done(done[1]), .overrun_cnt(ovr[1])
  );

  function automatic int sd(input int i);
    return (i == 0) ? 100 : 40;
  endfunction

  // Behavioural model: a frame is just (launch offset, latched words).
  int          cyc = 0;
  int          m_cnt [2];
  bit          m_act [2];
  int          m_off [2];
  logic [15:0] m_fa  [2];
  logic [15:0] m_fb  [2];
  int          m_ovr [2];
  bit          m_done[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_act[i] = 0; m_off[i] = 0; m_fa[i] = '0; m_fb[i] = '0;
      m_ovr[i] = 0; m_done[i] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          m_cnt[i] = 0; m_act[i] = 0; m_off[i] = 0; m_ovr[i] = 0; m_done[i] = 0;
        end else begin
          bit tk, was;
          tk = enable && (m_cnt[i] == sd(i) - 1);
          m_cnt[i] = (enable && !tk) ? m_cnt[i] + 1 : 0;
          was = m_act[i];
          m_done[i] = 0;
          if (m_act[i]) begin
            m_off[i]++;
            if (m_off[i] == 32 * H) begin
              m_act[i] = 0;
              m_done[i] = 1;
            end
          end
          if (tk) begin
            if (was) m_ovr[i] = (m_ovr[i] < 255) ? m_ovr[i] + 1 : 255;
            else begin
              m_act[i] = 1;
              m_off[i] = 0;
              m_fa[i]  = {2'b00, pd_mode, sample_in};
              m_fb[i]  = {2'b00, pd_mode, sample_in_b};
            end
          end
        end
      end
    end
  end

  // Control from stimulus to the compare process
  bit          lit_en = 0, per_en = 0, quiet_en = 0, final_req = 0;
  logic [15:0] lit_a = '0, lit_b = '0;
  int          exp_fall [2];

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  initial begin
    logic [1:0] prev_sync, prev_sclk;
    int         last_fall [2];
    logic [15:0] cap_a, cap_b;
    int         lowcnt, nfe;
    prev_sync = 2'b11; prev_sclk = 2'b11;
    last_fall[0] = -1; last_fall[1] = -1;
    cap_a = '0; cap_b = '0; lowcnt = 0; nfe = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        string s;
        s = $sformatf("dut%0d", i);
        if (!rst_n) begin
          chk({s, ".rst_sclk"},   int'(sclk[i]),   1);
          chk({s, ".rst_sync_n"}, int'(sync_n[i]), 1);
          chk({s, ".rst_din"},    int'(din[i]),    0);
          chk({s, ".rst_din_b"},  int'(din_b[i]),  0);
          chk({s, ".rst_busy"},   int'(busy[i]),   0);
          chk({s, ".rst_done"},   int'(done[i]),   0);
          chk({s, ".rst_ovr"},    int'(ovr[i]),    0);
          prev_sync[i] = 1'b1; prev_sclk[i] = 1'b1; last_fall[i] = -1;
        end else begin
          int e_sync, e_sclk, e_din, e_dinb, e_busy, idx;
          if (m_act[i]) begin
            idx    = 15 - m_off[i] / (2 * H);
            e_sync = 0;
            e_sclk = ((m_off[i] / H) % 2 == 1) ? 0 : 1;
            e_din  = int'(m_fa[i][idx]);
            e_dinb = DUAL ? int'(m_fb[i][idx]) : 0;
            e_busy = 1;
          end else begin
            e_sync = 1; e_sclk = 1; e_din = 0; e_dinb = 0; e_busy = 0;
          end
          chk({s, ".sync_n"}, int'(sync_n[i]), e_sync);
          chk({s, ".sclk"},   int'(sclk[i]),   e_sclk);
          chk({s, ".din"},    int'(din[i]),    e_din);
          chk({s, ".din_b"},  int'(din_b[i]),  e_dinb);
          chk({s, ".busy"},   int'(busy[i]),   e_busy);
          chk({s, ".frame_done"}, int'(done[i]), int'(m_done[i]));
          chk({s, ".overrun_cnt"}, int'(ovr[i]), m_ovr[i]);

          if (prev_sync[i] && !sync_n[i]) begin
            if (exp_fall[i] >= 0) chk({s, ".launch_cycle"}, cyc, exp_fall[i]);
            if (per_en && last_fall[i] >= 0)
              chk({s, ".frame_period"}, cyc - last_fall[i], (i == 0) ? 100 : 80);
            last_fall[i] = cyc;
          end
          prev_sync[i] = sync_n[i];
        end
      end

      if (rst_n) begin
        if (prev_sync[0] == 1'b0 && lowcnt == 0) begin
          lowcnt = 1; nfe = 0; cap_a = '0; cap_b = '0;
        end else if (!sync_n[0]) begin
          lowcnt++;
        end
        if (prev_sclk[0] && !sclk[0] && !sync_n[0]) begin
          cap_a = {cap_a[14:0], din[0]};
          cap_b = {cap_b[14:0], din_b[0]};
          nfe++;
        end
        if (done[0]) begin
          chk("dut0.sync_low_cycles", lowcnt, 64);
          chk("dut0.falling_edges", nfe, 16);
          if (lit_en) begin
            chk("dut0.frame_word_a", int'(cap_a), int'(lit_a));
            chk("dut0.frame_word_b", int'(cap_b), int'(lit_b));
          end
          lowcnt = 0;
        end
        if (quiet_en) chk("dut0.no_frame_when_disabled", int'(sync_n[0]), 1);
        if (final_req) chk("dut1.overrun_saturated", int'(ovr[1]), 255);
        prev_sclk = sclk;
      end else begin
        lowcnt = 0; nfe = 0;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_sync0(input logic v, input int lim);
    int n;
    n = 0;
    while (sync_n[0] !== v) begin
      step();
      n++;
      if (n > lim) begin
        $display("FAIL wait_sync0: dac_sync_n stuck at %b, required %b within %0d cycles", sync_n[0], v, lim);
        $fatal(1, "bounded wait expired");
      end
    end
  endtask

  task automatic wait_done0(input int lim);
    int n;
    n = 0;
    while (done[0] !== 1'b1) begin
      step();
      n++;
      if (n > lim) begin
        $display("FAIL wait_done0: frame_done=%b, required 1 within %0d cycles", done[0], lim);
        $fatal(1, "bounded wait expired");
      end
    end
  endtask

  initial begin
    exp_fall[0] = -1; exp_fall[1] = -1;
    rst_n = 1'b0; enable = 1'b0; pd_mode = 2'b00;
    sample_in = 12'hA5C; sample_in_b = 12'h3C3;
    repeat (5) step();

    // Reset release with enable high, first frame carries 0x0A5C
    enable = 1'b1;
    step();
    lit_a = 16'h0A5C; lit_b = DUAL ? 16'h03C3 : 16'h0000; lit_en = 1;
    rst_n = 1'b1;
    exp_fall[0] = cyc + 100; exp_fall[1] = cyc + 40;
    wait_sync0(1'b0, 200);
    exp_fall[0] = -1; exp_fall[1] = -1;
    wait_done0(200);

    // Channel A zeros, channel B all ones
    sample_in = 12'h000; sample_in_b = 12'hFFF;
    lit_a = 16'h0000; lit_b = DUAL ? 16'h0FFF : 16'h0000;
    per_en = 1;
    wait_sync0(1'b0, 200);
    wait_done0(200);
    lit_en = 0;

    // Inputs moving every 7 cycles; long enough for >600 misses on dut1
    for (int k = 0; k < 7000; k++) begin
      sample_in   = sample_in + 12'h123;
      sample_in_b = sample_in_b - 12'h011;
      pd_mode     = 2'((k / 50) % 4);
      repeat (7) step();
    end
    final_req = 1;
    step();
    final_req = 0;
    per_en = 0;
    pd_mode = 2'b00;

    // enable drops 20 cycles into a frame
    wait_sync0(1'b1, 200);
    wait_sync0(1'b0, 200);
    repeat (20) step();
    enable = 1'b0;
    wait_done0(200);
    quiet_en = 1;
    repeat (300) step();
    quiet_en = 0;
    enable = 1'b1;
    exp_fall[0] = cyc + 100; exp_fall[1] = cyc + 40;
    wait_sync0(1'b0, 200);
    exp_fall[0] = -1; exp_fall[1] = -1;

    // Reset 20 cycles into a frame, asserted between clock edges
    repeat (20) step();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (20) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
